// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl
//
// Exception / ertn commit controller for the writeback stage. Watches the
// instruction in writeback together with the interrupt CSRs. When something
// has to be taken, it latches the event, emits a one-cycle commit pulse
// towards the CSR file together with a fetch redirect, and then holds the
// pipeline flush for FLUSH_CYCLES cycles. Writeback is stalled for as long as
// the controller is busy.
//
// Parameters
//   FLUSH_CYCLES    cycles flush_o stays high per event (1..15)
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous, active-high reset
//   wb_valid        writeback holds a valid instruction
//   wb_pc           PC of the writeback instruction
//   wb_exc_adef     address-error-on-fetch flag
//   wb_exc_ine      instruction-not-exist flag
//   wb_exc_sys      syscall flag
//   wb_exc_brk      break flag
//   wb_exc_ale      address-alignment-error flag
//   wb_ertn         writeback instruction is ertn
//   csr_estat_is    ESTAT.IS pending interrupt bits
//   csr_ecfg_lie    ECFG.LIE local interrupt enables
//   csr_crmd_ie     CRMD.IE global interrupt enable
//   csr_eentry      exception entry address
//   csr_era         exception return address
//   wb_ex           one-cycle exception commit pulse
//   wb_ecode        exception code (meaningful while wb_ex=1)
//   wb_esubcode     exception subcode (meaningful while wb_ex=1)
//   ex_pc           PC to write into ERA (meaningful while wb_ex=1)
//   eret_flush      one-cycle ertn commit pulse
//   flush_o         pipeline flush
//   redirect_valid  one-cycle fetch redirect pulse
//   redirect_pc     fetch redirect target
//   wb_stall        writeback must hold (controller busy)
// ---------------------------------------------------------------------------
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_exc_adef,
    input  logic        wb_exc_ine,
    input  logic        wb_exc_sys,
    input  logic        wb_exc_brk,
    input  logic        wb_exc_ale,
    input  logic        wb_ertn,
    input  logic [12:0] csr_estat_is,
    input  logic [12:0] csr_ecfg_lie,
    input  logic        csr_crmd_ie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] ex_pc,
    output logic        eret_flush,
    output logic        flush_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wb_stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // The COMMIT cycle already counts as the first flush cycle, so the
    // counter only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         SKIP_FLUSH = (FLUSH_CYCLES <= 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  flush_cnt;

    logic        int_pending;
    logic        exc_any;
    logic [5:0]  exc_code;
    logic        take_ex;
    logic        take_ertn;
    logic        accept;

    logic        kind_ertn;
    logic [5:0]  ecode_q;
    logic [8:0]  esubcode_q;
    logic [31:0] ex_pc_q;
    logic [31:0] redirect_pc_q;

    // Interrupt qualification and exception priority encoding. Interrupts
    // outrank every synchronous exception; the remaining order is fixed.
    always_comb begin
        int_pending = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
        exc_any     = int_pending | wb_exc_adef | wb_exc_ine | wb_exc_sys
                    | wb_exc_brk | wb_exc_ale;
        exc_code    = ECODE_INT;
        if (int_pending) begin
            exc_code = ECODE_INT;
        end else if (wb_exc_adef) begin
            exc_code = ECODE_ADEF;
        end else if (wb_exc_ine) begin
            exc_code = ECODE_INE;
        end else if (wb_exc_sys) begin
            exc_code = ECODE_SYS;
        end else if (wb_exc_brk) begin
            exc_code = ECODE_BRK;
        end else if (wb_exc_ale) begin
            exc_code = ECODE_ALE;
        end
    end

    // Events are only looked at while idle. An ertn that coincides with a
    // qualifying exception or interrupt is dropped in favour of the exception.
    always_comb begin
        take_ex   = (state == IDLE) && wb_valid && exc_any;
        take_ertn = (state == IDLE) && wb_valid && wb_ertn && !exc_any;
        accept    = take_ex || take_ertn;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. With a single flush cycle the FLUSH state is
    // skipped entirely, which lets a new event be accepted two cycles later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (SKIP_FLUSH) begin
                    state_next = IDLE;
                end else begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt <= 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flush counter: loaded when leaving COMMIT, counts down in FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= 4'd0;
        end else if (state == COMMIT) begin
            flush_cnt <= CNT_LOAD;
        end else if (state == FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Event capture. Everything the CSR file and fetch need later is sampled
    // in the accept cycle, so CSR or pending-bit changes while busy are
    // invisible. The exception code is only updated for real exceptions and
    // otherwise keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_ertn     <= 1'b0;
            ecode_q       <= 6'd0;
            esubcode_q    <= 9'd0;
            ex_pc_q       <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else if (take_ex) begin
            kind_ertn     <= 1'b0;
            ecode_q       <= exc_code;
            esubcode_q    <= 9'd0;
            ex_pc_q       <= wb_pc;
            redirect_pc_q <= csr_eentry;
        end else if (take_ertn) begin
            kind_ertn     <= 1'b1;
            ex_pc_q       <= wb_pc;
            redirect_pc_q <= csr_era;
        end
    end

    // Outputs. Commit pulses are masked by reset so that a reset arriving
    // during COMMIT never lets a commit escape to the CSR file.
    always_comb begin
        wb_ex          = (state == COMMIT) && !kind_ertn && !reset;
        eret_flush     = (state == COMMIT) &&  kind_ertn && !reset;
        redirect_valid = (state == COMMIT) && !reset;
        flush_o        = (state != IDLE);
        wb_stall       = (state != IDLE);
        wb_ecode       = ecode_q;
        wb_esubcode    = esubcode_q;
        ex_pc          = ex_pc_q;
        redirect_pc    = redirect_pc_q;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl
//
// Testbench for exc_ctrl. Two instances share all inputs: dut_a with the
// default two flush cycles and dut_b with a single flush cycle. Directed
// scenarios check the documented behaviour against literal values, and a
// randomized phase checks both instances cycle by cycle against a reference
// model that tracks "cycles still busy" plus the captured event.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale;
    logic        wb_ertn;
    logic [12:0] csr_estat_is, csr_ecfg_lie;
    logic        csr_crmd_ie;
    logic [31:0] csr_eentry, csr_era;

    logic        wb_ex_a, eret_flush_a, flush_o_a, redirect_valid_a, wb_stall_a;
    logic [5:0]  wb_ecode_a;
    logic [8:0]  wb_esubcode_a;
    logic [31:0] ex_pc_a, redirect_pc_a;

    logic        wb_ex_b, eret_flush_b, flush_o_b, redirect_valid_b, wb_stall_b;
    logic [5:0]  wb_ecode_b;
    logic [8:0]  wb_esubcode_b;
    logic [31:0] ex_pc_b, redirect_pc_b;

    int total;
    int bad;

    // Reference model state, index 0 = dut_a, index 1 = dut_b.
    int          fc_of  [2] = '{2, 1};
    int          m_rem  [2];
    bit          m_ertn [2];
    logic [5:0]  m_ecode[2];
    logic [31:0] m_expc [2];
    logic [31:0] m_rpc  [2];

    exc_ctrl #(.FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
        .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex_a), .wb_ecode(wb_ecode_a), .wb_esubcode(wb_esubcode_a), .ex_pc(ex_pc_a),
        .eret_flush(eret_flush_a), .flush_o(flush_o_a), .redirect_valid(redirect_valid_a),
        .redirect_pc(redirect_pc_a), .wb_stall(wb_stall_a)
    );

    exc_ctrl #(.FLUSH_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
        .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex_b), .wb_ecode(wb_ecode_b), .wb_esubcode(wb_esubcode_b), .ex_pc(ex_pc_b),
        .eret_flush(eret_flush_b), .flush_o(flush_o_b), .redirect_valid(redirect_valid_b),
        .redirect_pc(redirect_pc_b), .wb_stall(wb_stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exception code an accepted event should report, from the priority list.
    function automatic logic [5:0] ref_code(bit intp);
        if (intp)        return 6'h00;
        if (wb_exc_adef) return 6'h08;
        if (wb_exc_ine)  return 6'h0D;
        if (wb_exc_sys)  return 6'h0B;
        if (wb_exc_brk)  return 6'h0C;
        return 6'h09;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    function automatic void model_edge();
        bit intp, exc;
        intp = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'd0);
        exc  = intp || wb_exc_adef || wb_exc_ine || wb_exc_sys || wb_exc_brk || wb_exc_ale;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_ertn[k] = 0; m_ecode[k] = '0; m_expc[k] = '0; m_rpc[k] = '0;
            end else if (m_rem[k] > 0) begin
                m_rem[k] = m_rem[k] - 1;
            end else if (wb_valid && exc) begin
                m_rem[k] = fc_of[k]; m_ertn[k] = 0; m_ecode[k] = ref_code(intp);
                m_expc[k] = wb_pc; m_rpc[k] = csr_eentry;
            end else if (wb_valid && wb_ertn) begin
                m_rem[k] = fc_of[k]; m_ertn[k] = 1; m_expc[k] = wb_pc; m_rpc[k] = csr_era;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_pc = '0; wb_ertn = 0;
        wb_exc_adef = 0; wb_exc_ine = 0; wb_exc_sys = 0; wb_exc_brk = 0; wb_exc_ale = 0;
        csr_estat_is = '0; csr_ecfg_lie = '0; csr_crmd_ie = 0;
        csr_eentry = 32'h1c008000; csr_era = 32'h1c000104;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step(); step();
        total++; if (wb_ex_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_wb_ex got=%0b want=0", wb_ex_a); end
        total++; if (eret_flush_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_eret got=%0b want=0", eret_flush_a); end
        total++; if (flush_o_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush got=%0b want=0", flush_o_a); end
        total++; if (redirect_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_rv got=%0b want=0", redirect_valid_a); end
        total++; if (wb_stall_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0b want=0", wb_stall_a); end
        total++; if (wb_ecode_a !== 6'd0) begin bad++; $display("[TB] FAIL rst_ecode got=%h want=0", wb_ecode_a); end
        total++; if (wb_esubcode_a !== 9'd0) begin bad++; $display("[TB] FAIL rst_esub got=%h want=0", wb_esubcode_a); end
        total++; if (ex_pc_a !== 32'd0) begin bad++; $display("[TB] FAIL rst_expc got=%h want=0", ex_pc_a); end
        total++; if (redirect_pc_a !== 32'd0) begin bad++; $display("[TB] FAIL rst_rpc got=%h want=0", redirect_pc_a); end
        total++; if (flush_o_b !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush_b got=%0b want=0", flush_o_b); end
        reset = 0;
    endtask

    task automatic test_syscall();
        clear_inputs();
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000100; csr_eentry = 32'h1c008000;
        step();
        total++; if (wb_ex_a !== 1'b1) begin bad++; $display("[TB] FAIL sys_wb_ex got=%0b want=1", wb_ex_a); end
        total++; if (wb_ecode_a !== 6'h0B) begin bad++; $display("[TB] FAIL sys_ecode got=%h want=0b", wb_ecode_a); end
        total++; if (ex_pc_a !== 32'h1c000100) begin bad++; $display("[TB] FAIL sys_expc got=%h want=1c000100", ex_pc_a); end
        total++; if (redirect_pc_a !== 32'h1c008000) begin bad++; $display("[TB] FAIL sys_rpc got=%h want=1c008000", redirect_pc_a); end
        total++; if (redirect_valid_a !== 1'b1) begin bad++; $display("[TB] FAIL sys_rv got=%0b want=1", redirect_valid_a); end
        total++; if (eret_flush_a !== 1'b0) begin bad++; $display("[TB] FAIL sys_eret got=%0b want=0", eret_flush_a); end
        total++; if (flush_o_a !== 1'b1 || wb_stall_a !== 1'b1) begin bad++; $display("[TB] FAIL sys_flush1 got=%0b/%0b want=1/1", flush_o_a, wb_stall_a); end
        clear_inputs();
        step();
        total++; if (wb_ex_a !== 1'b0 || redirect_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL sys_pulse_once got=%0b/%0b want=0/0", wb_ex_a, redirect_valid_a); end
        total++; if (flush_o_a !== 1'b1) begin bad++; $display("[TB] FAIL sys_flush2 got=%0b want=1", flush_o_a); end
        total++; if (flush_o_b !== 1'b0) begin bad++; $display("[TB] FAIL sys_flush_b got=%0b want=0", flush_o_b); end
        step();
        total++; if (flush_o_a !== 1'b0 || wb_stall_a !== 1'b0) begin bad++; $display("[TB] FAIL sys_flush_end got=%0b/%0b want=0/0", flush_o_a, wb_stall_a); end
        total++; if (wb_ecode_a !== 6'h0B || redirect_pc_a !== 32'h1c008000) begin bad++; $display("[TB] FAIL sys_hold got=%h/%h want=0b/1c008000", wb_ecode_a, redirect_pc_a); end
    endtask

    task automatic test_int_priority();
        clear_inputs();
        csr_estat_is = 13'h800; csr_ecfg_lie = 13'h800; csr_crmd_ie = 1;
        wb_valid = 1; wb_exc_brk = 1; wb_pc = 32'h1c000200;
        step();
        total++; if (wb_ex_a !== 1'b1 || wb_ecode_a !== 6'h00) begin bad++; $display("[TB] FAIL int_beats_brk got=%0b/%h want=1/00", wb_ex_a, wb_ecode_a); end
        clear_inputs();
        step(); step();
        csr_estat_is = 13'h800; csr_ecfg_lie = 13'h800; csr_crmd_ie = 0;
        wb_valid = 1; wb_exc_brk = 1; wb_pc = 32'h1c000204;
        step();
        total++; if (wb_ex_a !== 1'b1 || wb_ecode_a !== 6'h0C) begin bad++; $display("[TB] FAIL int_masked_brk got=%0b/%h want=1/0c", wb_ex_a, wb_ecode_a); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_ertn();
        clear_inputs();
        wb_valid = 1; wb_ertn = 1; csr_era = 32'h1c000104; wb_pc = 32'h1c000300;
        step();
        total++; if (eret_flush_a !== 1'b1 || wb_ex_a !== 1'b0) begin bad++; $display("[TB] FAIL ertn_pulse got=%0b/%0b want=1/0", eret_flush_a, wb_ex_a); end
        total++; if (redirect_valid_a !== 1'b1 || redirect_pc_a !== 32'h1c000104) begin bad++; $display("[TB] FAIL ertn_redirect got=%0b/%h want=1/1c000104", redirect_valid_a, redirect_pc_a); end
        clear_inputs();
        step(); step();
        wb_valid = 1; wb_ertn = 1; wb_exc_ine = 1; wb_pc = 32'h1c000308;
        step();
        total++; if (wb_ex_a !== 1'b1 || wb_ecode_a !== 6'h0D || eret_flush_a !== 1'b0) begin bad++; $display("[TB] FAIL ertn_ine got=%0b/%h/%0b want=1/0d/0", wb_ex_a, wb_ecode_a, eret_flush_a); end
        total++; if (redirect_pc_a !== 32'h1c008000) begin bad++; $display("[TB] FAIL ertn_ine_rpc got=%h want=1c008000", redirect_pc_a); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_priority_ignore();
        clear_inputs();
        wb_valid = 1; wb_exc_adef = 1; wb_exc_ale = 1; wb_exc_sys = 1; wb_pc = 32'h1c000400;
        step();
        total++; if (wb_ex_a !== 1'b1 || wb_ecode_a !== 6'h08) begin bad++; $display("[TB] FAIL multi_adef got=%0b/%h want=1/08", wb_ex_a, wb_ecode_a); end
        clear_inputs();
        wb_valid = 1; wb_exc_brk = 1; wb_pc = 32'h1c000500;
        step();
        total++; if (wb_ex_a !== 1'b0) begin bad++; $display("[TB] FAIL busy_ignore1 got=%0b want=0", wb_ex_a); end
        step();
        total++; if (wb_ex_a !== 1'b0 || flush_o_a !== 1'b0 || wb_ecode_a !== 6'h08) begin bad++; $display("[TB] FAIL busy_ignore2 got=%0b/%0b/%h want=0/0/08", wb_ex_a, flush_o_a, wb_ecode_a); end
        clear_inputs();
        step();
        total++; if (wb_ex_a !== 1'b0) begin bad++; $display("[TB] FAIL busy_ignore3 got=%0b want=0", wb_ex_a); end
    endtask

    task automatic test_reset_abort();
        clear_inputs();
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000600;
        step();
        reset = 1;
        clear_inputs();
        #1;
        total++; if (wb_ex_a !== 1'b0 || redirect_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_commit got=%0b/%0b want=0/0", wb_ex_a, redirect_valid_a); end
        step();
        total++; if (flush_o_a !== 1'b0 || wb_stall_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_commit_idle got=%0b/%0b want=0/0", flush_o_a, wb_stall_a); end
        reset = 0;
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000700;
        step();
        clear_inputs();
        step();
        total++; if (flush_o_a !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_flush got=%0b want=1", flush_o_a); end
        reset = 1;
        step();
        total++; if (flush_o_a !== 1'b0 || wb_stall_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_flush got=%0b/%0b want=0/0", flush_o_a, wb_stall_a); end
        total++; if (wb_ecode_a !== 6'd0 || ex_pc_a !== 32'd0 || redirect_pc_a !== 32'd0) begin bad++; $display("[TB] FAIL abort_regs got=%h/%h/%h want=0/0/0", wb_ecode_a, ex_pc_a, redirect_pc_a); end
        reset = 0;
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000800;
        step();
        total++; if (wb_ex_a !== 1'b1 || wb_ecode_a !== 6'h0B || ex_pc_a !== 32'h1c000800) begin bad++; $display("[TB] FAIL after_abort got=%0b/%h/%h want=1/0b/1c000800", wb_ex_a, wb_ecode_a, ex_pc_a); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        wb_valid = 1; wb_exc_sys = 1; wb_pc = 32'h1c000900;
        step();
        total++; if (wb_ex_b !== 1'b1 || flush_o_b !== 1'b1 || wb_ex_a !== 1'b1) begin bad++; $display("[TB] FAIL b2b_t1 got=%0b/%0b/%0b want=1/1/1", wb_ex_b, flush_o_b, wb_ex_a); end
        step();
        total++; if (wb_ex_b !== 1'b0 || flush_o_b !== 1'b0 || wb_stall_b !== 1'b0) begin bad++; $display("[TB] FAIL b2b_t2 got=%0b/%0b/%0b want=0/0/0", wb_ex_b, flush_o_b, wb_stall_b); end
        total++; if (wb_ex_a !== 1'b0 || flush_o_a !== 1'b1) begin bad++; $display("[TB] FAIL b2b_a_t2 got=%0b/%0b want=0/1", wb_ex_a, flush_o_a); end
        step();
        total++; if (wb_ex_b !== 1'b1 || flush_o_b !== 1'b1) begin bad++; $display("[TB] FAIL b2b_t3 got=%0b/%0b want=1/1", wb_ex_b, flush_o_b); end
        total++; if (wb_ex_a !== 1'b0 || flush_o_a !== 1'b0 || wb_stall_a !== 1'b0) begin bad++; $display("[TB] FAIL b2b_a_t3 got=%0b/%0b/%0b want=0/0/0", wb_ex_a, flush_o_a, wb_stall_a); end
        step();
        total++; if (wb_ex_b !== 1'b0 || flush_o_b !== 1'b0) begin bad++; $display("[TB] FAIL b2b_t4 got=%0b/%0b want=0/0", wb_ex_b, flush_o_b); end
        total++; if (wb_ex_a !== 1'b1) begin bad++; $display("[TB] FAIL b2b_a_t4 got=%0b want=1", wb_ex_a); end
        clear_inputs();
        step(); step(); step();
    endtask

    task automatic test_random();
        logic       g_ex, g_er, g_fl, g_rv, g_st;
        logic [5:0] g_code;
        logic [31:0] g_expc, g_rpc;
        bit         commit, busy;
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 39) == 0);
            wb_valid     = $urandom_range(0, 1);
            wb_pc        = $urandom;
            wb_exc_adef  = ($urandom_range(0, 9) == 0);
            wb_exc_ine   = ($urandom_range(0, 9) == 0);
            wb_exc_sys   = ($urandom_range(0, 7) == 0);
            wb_exc_brk   = ($urandom_range(0, 7) == 0);
            wb_exc_ale   = ($urandom_range(0, 9) == 0);
            wb_ertn      = ($urandom_range(0, 3) == 0);
            csr_estat_is = ($urandom_range(0, 3) == 0) ? 13'(1 << $urandom_range(0, 12)) : 13'd0;
            csr_ecfg_lie = 13'($urandom);
            csr_crmd_ie  = $urandom_range(0, 1);
            csr_eentry   = $urandom;
            csr_era      = $urandom;
            #1;
            for (int k = 0; k < 2; k++) begin
                g_ex   = (k == 0) ? wb_ex_a : wb_ex_b;
                g_er   = (k == 0) ? eret_flush_a : eret_flush_b;
                g_fl   = (k == 0) ? flush_o_a : flush_o_b;
                g_rv   = (k == 0) ? redirect_valid_a : redirect_valid_b;
                g_st   = (k == 0) ? wb_stall_a : wb_stall_b;
                g_code = (k == 0) ? wb_ecode_a : wb_ecode_b;
                g_expc = (k == 0) ? ex_pc_a : ex_pc_b;
                g_rpc  = (k == 0) ? redirect_pc_a : redirect_pc_b;
                busy   = (m_rem[k] > 0);
                commit = (m_rem[k] == fc_of[k]) && !reset;
                total++;
                if (g_ex !== (commit && !m_ertn[k]) || g_er !== (commit && m_ertn[k]) || g_rv !== commit) begin
                    bad++;
                    $display("[TB] FAIL rnd_pulses dut%0d cyc%0d got=%0b%0b%0b want=%0b%0b%0b", k, n, g_ex, g_er, g_rv,
                             commit && !m_ertn[k], commit && m_ertn[k], commit);
                end
                total++;
                if (g_fl !== busy || g_st !== busy) begin
                    bad++;
                    $display("[TB] FAIL rnd_flush dut%0d cyc%0d got=%0b/%0b want=%0b", k, n, g_fl, g_st, busy);
                end
                if (commit && !m_ertn[k]) begin
                    total++;
                    if (g_code !== m_ecode[k] || g_expc !== m_expc[k]) begin
                        bad++;
                        $display("[TB] FAIL rnd_exc dut%0d cyc%0d got=%h/%h want=%h/%h", k, n, g_code, g_expc, m_ecode[k], m_expc[k]);
                    end
                end
                if (commit) begin
                    total++;
                    if (g_rpc !== m_rpc[k]) begin
                        bad++;
                        $display("[TB] FAIL rnd_rpc dut%0d cyc%0d got=%h want=%h", k, n, g_rpc, m_rpc[k]);
                    end
                end
            end
            step();
        end
        reset = 0;
        clear_inputs();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_ertn[k] = 0; m_ecode[k] = '0; m_expc[k] = '0; m_rpc[k] = '0;
        end
        test_reset();
        test_syscall();
        test_int_priority();
        test_ertn();
        test_priority_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 FLUSH_CYCLES, default 2, number of cycles flush_o is held after an exception or ertn commit (legal range 1..15).
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb_valid  input  1  writeback stage holds a valid instruction this cycle.
REQ-005 wb_pc  input  32  PC of the writeback instruction.
REQ-006 wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale  input  1 each  exception flags carried by the writeback instruction.
REQ-007 wb_ertn  input  1  writeback instruction is ertn.
REQ-008 csr_estat_is  input  13  CSR ESTAT.IS pending bits.
REQ-009 csr_ecfg_lie  input  13  CSR ECFG.LIE enable bits.
REQ-010 csr_crmd_ie  input  1  CSR CRMD.IE global interrupt enable.
REQ-011 csr_eentry, csr_era  input  32 each  CSR EENTRY and ERA read values.
REQ-012 wb_ex  output  1  one-cycle exception-commit pulse to the CSR file.
REQ-013 wb_ecode  output  6  exception code for the CSR file, valid while wb_ex=1.
REQ-014 wb_esubcode  output  9  exception subcode, valid while wb_ex=1.
REQ-015 ex_pc  output  32  PC written to ERA, valid while wb_ex=1.
REQ-016 eret_flush  output  1  one-cycle ertn-commit pulse to the CSR file.
REQ-017 flush_o  output  1  pipeline flush, held FLUSH_CYCLES cycles.
REQ-018 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-019 redirect_pc  output  32  redirect target, valid while redirect_valid=1.
REQ-020 wb_stall  output  1  writeback must hold; high whenever state is not IDLE.

Function
REQ-021 States: IDLE, COMMIT, FLUSH; state register, 4-bit flush counter, registered ecode/esubcode/ex_pc/redirect_pc.
REQ-022 int_pending = csr_crmd_ie AND |(csr_estat_is AND csr_ecfg_lie), evaluated combinationally each cycle.
REQ-023 Events are accepted only in IDLE with wb_valid=1; wb_valid in COMMIT/FLUSH is ignored.
REQ-024 Priority, highest first: INT (ecode 0x00), ADEF (0x08, sub 0), INE (0x0D), SYS (0x0B), BRK (0x0C), ALE (0x09); esubcode is 0 for all.
REQ-025 ertn is taken only when no exception or interrupt qualifies in the same cycle; otherwise the exception wins and ertn is dropped.
REQ-026 Accept at cycle T: latch ecode, esubcode, ex_pc=wb_pc, kind (ex/ertn), redirect_pc = csr_eentry (ex) or csr_era (ertn) sampled at T; go to COMMIT.
REQ-027 COMMIT (T+1): wb_ex=1 (ex) or eret_flush=1 (ertn), redirect_valid=1, flush_o=1; load counter with FLUSH_CYCLES-1; go to FLUSH, or straight to IDLE if FLUSH_CYCLES=1.
REQ-028 FLUSH: flush_o=1, counter decrements each cycle; at counter=1 go IDLE next edge; total flush_o high exactly FLUSH_CYCLES cycles from T+1.
REQ-029 wb_ex, eret_flush, redirect_valid are never high in the same cycle as each other except redirect_valid with one of the two; each pulses exactly once per accepted event.
REQ-030 A new event may be accepted in the first IDLE cycle after FLUSH (back-to-back allowed, no bubble beyond flush).
REQ-031 Interrupt sampled only at acceptance; pending bits changing during COMMIT/FLUSH have no effect until IDLE.
REQ-032 Outputs wb_ecode, wb_esubcode, ex_pc, redirect_pc hold last latched value when not qualified.

Reset
REQ-033 reset forces state=IDLE, counter=0, wb_ex=0, eret_flush=0, flush_o=0, redirect_valid=0, wb_stall=0, wb_ecode=0, wb_esubcode=0, ex_pc=0, redirect_pc=0 on the next edge.
REQ-034 reset asserted in COMMIT or FLUSH aborts the sequence; no pulse is emitted in the reset cycle or after.

Verification
REQ-035 wb_valid=1, wb_exc_sys=1, pc=0x1c000100, eentry=0x1c008000 -> T+1 wb_ex=1, ecode=0x0B, ex_pc=0x1c000100, redirect_pc=0x1c008000; flush_o high 2 cycles.
REQ-036 is=0x800, lie=0x800, ie=1, wb_valid with wb_exc_brk=1 -> ecode=0x00 (INT beats BRK); same with ie=0 -> ecode=0x0C.
REQ-037 wb_ertn=1, era=0x1c000104, no exceptions -> T+1 eret_flush=1, wb_ex=0, redirect_pc=0x1c000104; ertn with wb_exc_ine=1 -> wb_ex=1, ecode=0x0D, eret_flush=0.
REQ-038 ADEF+ALE+SYS together -> ecode=0x08; wb_valid=1 with exc during FLUSH -> ignored, no second wb_ex.
REQ-039 reset asserted at first FLUSH cycle -> next cycle flush_o=0, wb_stall=0, state IDLE; following syscall processed normally.
REQ-040 FLUSH_CYCLES=1, two syscalls on consecutive accept opportunities -> wb_ex pulses at T+1 and T+3, flush_o high one cycle each.
